// File: rtl/apb_wr_master_if.sv
// Bus bundle for the APB write engine: FIFO read port, APB4 master signals
// and the per-beat response port. The master modport is the engine's view.
interface apb_wr_master_if #(
  parameter int ID_NUM = 4,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;
  localparam int PAY_W  = ID_NUM + ADDR_W + STRB_W + DATA_W;

  // FIFO read port (first-word-fall-through)
  logic              afifo_rvld;
  logic              afifo_rrdy;
  logic [PAY_W-1:0]  afifo_rpayload;

  // APB4 master
  logic              PSEL_o;
  logic              PENABLE_o;
  logic              PWRITE_o;
  logic [ADDR_W-1:0] PADDR_o;
  logic [DATA_W-1:0] PWDATA_o;
  logic [STRB_W-1:0] PSTRB_o;
  logic [2:0]        PPROT_o;
  logic              PREADY_i;
  logic              PSLVERR_i;

  // per-beat response
  logic              rsp_vld;
  logic              rsp_rdy;
  logic [ID_NUM-1:0] rsp_id;
  logic [1:0]        rsp_resp;

  modport master (
    input  afifo_rvld, afifo_rpayload, PREADY_i, PSLVERR_i, rsp_rdy,
    output afifo_rrdy, PSEL_o, PENABLE_o, PWRITE_o, PADDR_o, PWDATA_o,
           PSTRB_o, PPROT_o, rsp_vld, rsp_id, rsp_resp
  );

  modport slave (
    output afifo_rvld, afifo_rpayload, PREADY_i, PSLVERR_i, rsp_rdy,
    input  afifo_rrdy, PSEL_o, PENABLE_o, PWRITE_o, PADDR_o, PWDATA_o,
           PSTRB_o, PPROT_o, rsp_vld, rsp_id, rsp_resp
  );
endinterface

// File: rtl/apb_wr_master.sv
// APB4 write engine: pops one {id, addr, strb, data} beat from the async
// FIFO read port, runs a SETUP/ACCESS write, and posts (id, resp) into a
// single response register. A PREADY timeout aborts transfers to a hung slave.
module apb_wr_master #(
  parameter int ID_NUM      = 4,
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic             PCLK_i,
  input  logic             PRESETn_i,
  apb_wr_master_if.master  bus
);
  localparam int STRB_W = DATA_W / 8;
  localparam int PAY_W  = ID_NUM + ADDR_W + STRB_W + DATA_W;
  // Counter must hold 0..TIMEOUT_CYC; keep at least one bit when disabled.
  localparam int CNT_W  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam bit TMO_EN = (TIMEOUT_CYC != 0);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_TMO    = 2'b11;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;
  logic [STRB_W-1:0] pstrb_q;
  logic [ID_NUM-1:0] id_q;
  logic              rsp_vld_q;
  logic [ID_NUM-1:0] rsp_id_q;
  logic [1:0]        rsp_resp_q;

  logic              in_access;
  logic              tmo;
  logic              done;
  logic              rsp_free;
  logic              rrdy;
  logic              pop;
  logic [1:0]        resp_d;

  // payload fields, id in the MSBs
  logic [ID_NUM-1:0] pay_id;
  logic [ADDR_W-1:0] pay_addr;
  logic [STRB_W-1:0] pay_strb;
  logic [DATA_W-1:0] pay_data;

  assign pay_id   = bus.afifo_rpayload[PAY_W-1 -: ID_NUM];
  assign pay_addr = bus.afifo_rpayload[DATA_W+STRB_W +: ADDR_W];
  assign pay_strb = bus.afifo_rpayload[DATA_W +: STRB_W];
  assign pay_data = bus.afifo_rpayload[DATA_W-1:0];

  // Completion, timeout and pop qualification. A pop needs the response
  // register free, so at most one beat is ever in flight behind it.
  always_comb begin
    in_access = (state_q == S_ACCESS);
    tmo       = TMO_EN && in_access && (tmo_cnt_q == CNT_LAST) && !bus.PREADY_i;
    done      = in_access && (bus.PREADY_i || tmo);
    rsp_free  = !rsp_vld_q || bus.rsp_rdy;
    // PRESETn_i gating keeps the pop strobe low while reset is asserted
    rrdy      = PRESETn_i && rsp_free && ((state_q == S_IDLE) || done);
    pop       = bus.afifo_rvld && rrdy;
    // PREADY in the timeout cycle wins, so tmo already excludes it
    if (tmo)                resp_d = RESP_TMO;
    else if (bus.PSLVERR_i) resp_d = RESP_SLVERR;
    else                    resp_d = RESP_OKAY;
  end

  // Next-state and timeout counter logic
  always_comb begin
    state_d   = state_q;
    tmo_cnt_d = tmo_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (pop) state_d = S_SETUP;
      end
      S_SETUP: begin
        state_d   = S_ACCESS;
        tmo_cnt_d = '0;
      end
      S_ACCESS: begin
        if (!bus.PREADY_i) tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
        // ACCESS never waits on the response port
        if (done) state_d = pop ? S_SETUP : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and timeout counter registers
  always_ff @(posedge PCLK_i or negedge PRESETn_i) begin
    if (!PRESETn_i) begin
      state_q   <= S_IDLE;
      tmo_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  // Capture the popped beat; held stable through SETUP and ACCESS
  always_ff @(posedge PCLK_i or negedge PRESETn_i) begin
    if (!PRESETn_i) begin
      paddr_q  <= '0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
      id_q     <= '0;
    end else if (pop) begin
      paddr_q  <= pay_addr;
      pwdata_q <= pay_data;
      pstrb_q  <= pay_strb;
      id_q     <= pay_id;
    end
  end

  // Response register: a completion always loads it (even alongside rsp_rdy)
  always_ff @(posedge PCLK_i or negedge PRESETn_i) begin
    if (!PRESETn_i) begin
      rsp_vld_q  <= 1'b0;
      rsp_id_q   <= '0;
      rsp_resp_q <= RESP_OKAY;
    end else if (done) begin
      rsp_vld_q  <= 1'b1;
      rsp_id_q   <= id_q;
      rsp_resp_q <= resp_d;
    end else if (bus.rsp_rdy) begin
      rsp_vld_q  <= 1'b0;
    end
  end

  assign bus.afifo_rrdy = rrdy;
  assign bus.PSEL_o     = (state_q == S_SETUP) || in_access;
  assign bus.PENABLE_o  = in_access;
  assign bus.PWRITE_o   = bus.PSEL_o;
  assign bus.PADDR_o    = paddr_q;
  assign bus.PWDATA_o   = pwdata_q;
  assign bus.PSTRB_o    = pstrb_q;
  assign bus.PPROT_o    = 3'b000;
  assign bus.rsp_vld    = rsp_vld_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_resp   = rsp_resp_q;

endmodule

// File: tb/tb_apb_wr_master.sv
// Bench for apb_wr_master: a transaction-level model (FIFO queue, beat in
// flight with its age, one response slot) predicts every output each cycle
// under directed scenarios and randomized slave/FIFO/response behaviour.
module tb_apb_wr_master;
  localparam int ID_NUM = 4;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int TMO    = 8;

  typedef struct packed {
    logic [ID_NUM-1:0]   id;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W/8-1:0] strb;
    logic [DATA_W-1:0]   data;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  apb_wr_master_if #(.ID_NUM(ID_NUM), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  apb_wr_master #(.ID_NUM(ID_NUM), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TMO)) dut (
    .PCLK_i   (clk),
    .PRESETn_i(rst_n),
    .bus      (bus.master)
  );

  // reference model
  beat_t      fifo_q[$];
  beat_t      cur;
  bit         cur_v = 0;
  int         age = 0;          // cycles since pop: 1 = SETUP, >=2 = ACCESS
  bit         slot_v = 0;
  logic [3:0] slot_id;
  logic [1:0] slot_resp;

  // stimulus knobs
  int vld_pct = 100, rdy_pct = 100, pr_pct = 100, err_pct = 0;
  int pr_mode = 0;              // 0 random, 1 fixed wait_n waits, 2 never ready
  int wait_n = 0;

  // observations of the DUT
  logic [5:0] acc_q[$];
  int         acc_cyc[$];
  int         pen_cnt = 0, pop_cyc = 0, rsp_cyc = -1, cyc = 0;
  bit         rsp_prev = 0;
  logic [1:0] last_dut_resp = 2'b01;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic drive_idle();
    bus.afifo_rvld     = 1'b0;
    bus.afifo_rpayload = '0;
    bus.PREADY_i       = 1'b0;
    bus.PSLVERR_i      = 1'b0;
    bus.rsp_rdy        = 1'b0;
  endtask

  task automatic model_clear();
    fifo_q.delete();
    cur_v  = 0;
    age    = 0;
    slot_v = 0;
    rsp_prev = 0;
  endtask

  task automatic push(input logic [3:0] id, input logic [11:0] addr,
                      input logic [3:0] strb, input logic [31:0] data);
    beat_t b;
    b.id = id; b.addr = addr; b.strb = strb; b.data = data;
    fifo_q.push_back(b);
  endtask

  task automatic push_rand();
    push(4'($urandom), 12'($urandom), 4'($urandom), $urandom);
  endtask

  // One clock: check registered outputs, drive inputs, check the pop strobe,
  // then advance the model to what the next edge must produce.
  task automatic step();
    bit pready, pslverr, tmo, done, rfree, exp_rrdy, pop, acc;
    logic [63:0] r;
    @(negedge clk);
    cyc++;
    acc = cur_v && (age >= 2);
    chk("psel", bus.PSEL_o, cur_v);
    chk("penable", bus.PENABLE_o, acc);
    chk("pwrite", bus.PWRITE_o, cur_v);
    chk("pprot", bus.PPROT_o, 0);
    if (cur_v) begin
      chk("paddr", bus.PADDR_o, cur.addr);
      chk("pwdata", bus.PWDATA_o, cur.data);
      chk("pstrb", bus.PSTRB_o, cur.strb);
    end
    chk("rsp_vld", bus.rsp_vld, slot_v);
    if (slot_v) begin
      chk("rsp_id", bus.rsp_id, slot_id);
      chk("rsp_resp", bus.rsp_resp, slot_resp);
    end
    if (bus.PENABLE_o) pen_cnt++;
    if (bus.rsp_vld && !rsp_prev) begin
      rsp_cyc = cyc;
      last_dut_resp = bus.rsp_resp;
    end
    rsp_prev = bus.rsp_vld;

    r = {$urandom, $urandom};
    bus.afifo_rvld     = (fifo_q.size() > 0) && ($urandom_range(99) < vld_pct);
    bus.afifo_rpayload = (fifo_q.size() > 0) ? fifo_q[0] : r[51:0];
    if (acc) begin
      case (pr_mode)
        1:       pready = ((age - 1) == wait_n + 1);
        2:       pready = 1'b0;
        default: pready = ($urandom_range(99) < pr_pct);
      endcase
      pslverr = ($urandom_range(99) < err_pct);
    end else begin
      pready  = 1'($urandom_range(1));
      pslverr = 1'($urandom_range(1));
    end
    bus.PREADY_i  = pready;
    bus.PSLVERR_i = pslverr;
    bus.rsp_rdy   = ($urandom_range(99) < rdy_pct);
    #1;
    tmo      = acc && ((age - 1) == TMO) && !pready;
    done     = acc && (pready || tmo);
    rfree    = !slot_v || bus.rsp_rdy;
    exp_rrdy = rfree && (!cur_v || done);
    chk("afifo_rrdy", bus.afifo_rrdy, exp_rrdy);
    pop = exp_rrdy && bus.afifo_rvld;
    if (slot_v && bus.rsp_rdy) begin
      acc_q.push_back({bus.rsp_id, bus.rsp_resp});
      acc_cyc.push_back(cyc);
    end
    if (pop) pop_cyc = cyc;
    if (done) begin
      slot_v    = 1;
      slot_id   = cur.id;
      slot_resp = tmo ? 2'b11 : (pslverr ? 2'b10 : 2'b00);
      cur_v     = 0;
    end else if (bus.rsp_rdy) begin
      slot_v = 0;
    end
    if (pop) begin
      cur   = fifo_q.pop_front();
      cur_v = 1;
      age   = 1;
    end else if (cur_v) begin
      age++;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_psel"}, bus.PSEL_o, 0);
    chk({tag, "_penable"}, bus.PENABLE_o, 0);
    chk({tag, "_pwrite"}, bus.PWRITE_o, 0);
    chk({tag, "_rrdy"}, bus.afifo_rrdy, 0);
    chk({tag, "_rsp_vld"}, bus.rsp_vld, 0);
  endtask

  task automatic fast_knobs();
    vld_pct = 100; rdy_pct = 100; pr_mode = 0; pr_pct = 100; err_pct = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    drive_idle();
    #12;
    check_reset_outputs("rst");
    chk("rst_paddr", bus.PADDR_o, 0);
    chk("rst_pwdata", bus.PWDATA_o, 0);
    chk("rst_pstrb", bus.PSTRB_o, 0);
    chk("rst_rsp_id", bus.rsp_id, 0);
    chk("rst_rsp_resp", bus.rsp_resp, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    fast_knobs();
    run(3);

    // single zero-wait beat: SETUP, ACCESS, response three cycles after pop
    acc_q.delete(); acc_cyc.delete(); rsp_cyc = -1;
    push(4'd3, 12'h104, 4'hF, 32'hDEADBEEF);
    run(6);
    chk("t1_latency", rsp_cyc - pop_cyc, 3);
    chk("t1_resp", last_dut_resp, 2'b00);
    chk("t1_count", acc_q.size(), 1);
    if (acc_q.size() > 0) chk("t1_id", acc_q[0][5:2], 4'd3);

    // four back-to-back beats: one response every two cycles, in order
    acc_q.delete(); acc_cyc.delete();
    for (int i = 0; i < 4; i++) push(4'(4 + i), 12'(16 * i), 4'hF, $urandom);
    run(14);
    chk("t2_count", acc_q.size(), 4);
    for (int i = 0; i < acc_q.size(); i++) chk("t2_order", acc_q[i][5:2], 4 + i);
    for (int i = 1; i < acc_cyc.size(); i++) chk("t2_gap", acc_cyc[i] - acc_cyc[i-1], 2);

    // five wait states, then PREADY with PSLVERR
    pr_mode = 1; wait_n = 5; err_pct = 100; pen_cnt = 0;
    push(4'd9, 12'h200, 4'h3, 32'h12345678);
    run(12);
    chk("t3_access_cycles", pen_cnt, 6);
    chk("t3_resp", last_dut_resp, 2'b10);

    // hung slave: abort after TMO ACCESS cycles, next beat normal
    acc_q.delete();
    pr_mode = 2; err_pct = 0; pen_cnt = 0;
    push(4'd10, 12'h300, 4'hF, 32'hA5A5A5A5);
    run(14);
    chk("t4_access_cycles", pen_cnt, TMO);
    chk("t4_tmo_resp", last_dut_resp, 2'b11);
    fast_knobs();
    push(4'd11, 12'h304, 4'hF, 32'h5A5A5A5A);
    run(6);
    chk("t4_count", acc_q.size(), 2);
    if (acc_q.size() == 2) chk("t4_next_resp", acc_q[1], {4'd11, 2'b00});

    // response stalled: the beat popped as beat 1 completes (slot still
    // empty) overwrites it; after that the pop strobe stays low
    acc_q.delete();
    rdy_pct = 0;
    for (int i = 1; i <= 3; i++) push(4'(i), 12'(i), 4'hF, $urandom);
    run(10);
    chk("t5_fifo_left", fifo_q.size(), 1);
    chk("t5_rrdy", bus.afifo_rrdy, 0);
    chk("t5_rsp_id", bus.rsp_id, 4'd2);
    rdy_pct = 100;
    run(8);
    chk("t5_drained", fifo_q.size(), 0);
    chk("t5_count", acc_q.size(), 2);

    // randomized traffic
    for (int rnd = 0; rnd < 10; rnd++) begin
      vld_pct = $urandom_range(100, 30);
      rdy_pct = $urandom_range(100, 20);
      pr_pct  = $urandom_range(100, 10);
      err_pct = $urandom_range(50);
      pr_mode = (rnd % 4 == 3) ? 1 : 0;
      wait_n  = $urandom_range(TMO + 2);
      for (int i = 0; i < 200; i++) begin
        if (fifo_q.size() < 8 && $urandom_range(99) < 30) push_rand();
        step();
      end
    end
    fast_knobs();
    run(60);
    chk("drain_psel", bus.PSEL_o, 0);
    chk("drain_rsp_vld", bus.rsp_vld, 0);

    // reset in the middle of ACCESS with a response pending
    rdy_pct = 0; pr_mode = 2;
    push(4'd12, 12'h400, 4'hF, $urandom);
    push(4'd13, 12'h404, 4'hF, $urandom);
    run(16);
    chk("t6_pre_penable", bus.PENABLE_o, 1);
    chk("t6_pre_rsp_vld", bus.rsp_vld, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    drive_idle();
    #1;
    check_reset_outputs("t6");
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    fast_knobs();
    acc_q.delete();
    push(4'd14, 12'h408, 4'hC, 32'hCAFEF00D);
    run(8);
    chk("t6_count", acc_q.size(), 1);
    if (acc_q.size() > 0) chk("t6_after", acc_q[0], {4'd14, 2'b00});

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
